// File: rtl/daq_pkg.sv
// daq_pkg: shared definitions for the DAQ transmit sequencer.
//   seq_state_t      sequencer FSM states (S_TRAILER only with DAQ_SEQ_TRAILER_EN)
//   hs_state_t       byte-handshake engine states
//   DAQ_HDR_PREFIX   top three bits of a channel header byte (bit 7 = 0: control)
//   DAQ_TRAILER_BYTE byte sent after the last channel when DAQ_SEQ_TRAILER_EN is defined
//   DAQ_MAX_CH       upper bound on channel count
//   lowest_set()     priority encoder, index of the lowest set bit
package daq_pkg;

  localparam int unsigned DAQ_MAX_CH       = 32;
  localparam logic [2:0]  DAQ_HDR_PREFIX   = 3'b000;
  localparam logic [7:0]  DAQ_TRAILER_BYTE = 8'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_STREAM,
    S_RELEASE,
    S_DONE
`ifdef DAQ_SEQ_TRAILER_EN
    ,
    S_TRAILER
`endif
  } seq_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ACK,
    HS_REL
  } hs_state_t;

  function automatic logic [4:0] lowest_set(input logic [DAQ_MAX_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = DAQ_MAX_CH; i > 0; i--) begin
      if (v[i-1]) idx = 5'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/daq_byte_handshake.sv
// daq_byte_handshake: four-phase ready/loaded handshake for bytes the
// sequencer originates itself (channel header, trailer).
//   tx_clk, reset  clock, asynchronous active-high reset
//   send_i         request: a byte is waiting to go out
//   byte_i         byte to send, captured when the handshake starts
//   loaded_s_i     synchronised UART loaded flag
//   ready_o        byte valid (registered)
//   data_o         byte (registered, stable while ready_o = 1)
//   sent_o         high in the cycle the UART has released the byte
module daq_byte_handshake
  import daq_pkg::*;
(
  input  logic       tx_clk,
  input  logic       reset,
  input  logic       send_i,
  input  logic [7:0] byte_i,
  input  logic       loaded_s_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       sent_o
);

  hs_state_t  st_q;
  logic       ready_q;
  logic [7:0] data_q;

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      st_q    <= HS_IDLE;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (st_q)
        HS_IDLE: if (send_i && !loaded_s_i) begin
          ready_q <= 1'b1;
          data_q  <= byte_i;
          st_q    <= HS_ACK;
        end
        HS_ACK: if (loaded_s_i) begin
          ready_q <= 1'b0;
          st_q    <= HS_REL;
        end
        HS_REL: if (!loaded_s_i) st_q <= HS_IDLE;
        default: st_q <= HS_IDLE;
      endcase
    end
  end

  // Combinational so the sequencer leaves its header state on the same edge
  // the engine returns to idle, and the engine never re-arms on a stale send.
  assign sent_o  = (st_q == HS_REL) && !loaded_s_i;
  assign ready_o = ready_q;
  assign data_o  = data_q;

endmodule

// File: rtl/daq_tx_sequencer.sv
// daq_tx_sequencer: shares one UART between N_CH DAQ RAM channels.
// On start, walks enabled channels in ascending order: header byte
// {0,00,ch}, then grants the channel and forwards its byte stream until it
// reports complete. Optional 0x7F trailer with DAQ_SEQ_TRAILER_EN defined.
//   tx_clk, reset      clock, asynchronous active-high reset
//   start, ch_mask     readout request (IDLE only), channel enables
//   busy, done         readout in progress, one-cycle end pulse
//   tx_en              one-hot grant to the streaming channel
//   ch_data_ready, ch_data, ch_complete  per-channel stream inputs
//   ch_data_loaded     raw uart_loaded routed to the granted channel
//   uart_data_ready, uart_data, uart_loaded  UART side
module daq_tx_sequencer
  import daq_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic              tx_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_mask,
  output logic              busy,
  output logic              done,
  output logic [N_CH-1:0]   tx_en,
  input  logic [N_CH-1:0]   ch_data_ready,
  input  logic [8*N_CH-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_complete,
  output logic [N_CH-1:0]   ch_data_loaded,
  output logic              uart_data_ready,
  output logic [7:0]        uart_data,
  input  logic              uart_loaded
);

  logic [1:0]            sync_q;
  logic                  loaded_s;
  seq_state_t            state_q;
  logic [4:0]            ch_q;
  logic [N_CH-1:0]       mask_q;
  logic [N_CH-1:0]       tx_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  uart_rdy_q;
  logic [7:0]            uart_dat_q;

  logic [DAQ_MAX_CH-1:0] req_w;
  logic [DAQ_MAX_CH-1:0] above_w;
  logic [N_CH-1:0]       grant_oh;
  logic                  sel_ready;
  logic                  sel_complete;
  logic [7:0]            sel_data;
  logic                  hs_send;
  logic [7:0]            hs_byte;
  logic                  hs_ready;
  logic [7:0]            hs_data;
  logic                  hs_sent;

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], uart_loaded};
  end
  assign loaded_s = sync_q[1];

  always_comb begin
    logic [DAQ_MAX_CH-1:0] mask_w;
    mask_w               = '0;
    mask_w[N_CH-1:0]     = mask_q;
    req_w                = '0;
    req_w[N_CH-1:0]      = ch_mask;
    // Enabled channels strictly above the current one.
    above_w      = mask_w & ~((32'd2 << ch_q) - 32'd1);
    grant_oh     = '0;
    sel_ready    = 1'b0;
    sel_complete = 1'b0;
    sel_data     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      grant_oh[i] = (ch_q == 5'(i));
      if (grant_oh[i]) begin
        sel_ready    = ch_data_ready[i];
        sel_complete = ch_complete[i];
        sel_data     = ch_data[8*i +: 8];
      end
    end
    hs_send = (state_q == S_HDR);
    hs_byte = {DAQ_HDR_PREFIX, ch_q};
`ifdef DAQ_SEQ_TRAILER_EN
    if (state_q == S_TRAILER) begin
      hs_send = 1'b1;
      hs_byte = DAQ_TRAILER_BYTE;
    end
`endif
  end

  daq_byte_handshake u_hs (
    .tx_clk     (tx_clk),
    .reset      (reset),
    .send_i     (hs_send),
    .byte_i     (hs_byte),
    .loaded_s_i (loaded_s),
    .ready_o    (hs_ready),
    .data_o     (hs_data),
    .sent_o     (hs_sent)
  );

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      mask_q     <= '0;
      tx_en_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      uart_rdy_q <= 1'b0;
      uart_dat_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_en_q    <= '0;
          uart_rdy_q <= 1'b0;
          uart_dat_q <= '0;
          if (start) begin
            if (|ch_mask) begin
              mask_q  <= ch_mask;
              ch_q    <= lowest_set(req_w);
              busy_q  <= 1'b1;
              state_q <= S_HDR;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_HDR: begin
          uart_rdy_q <= hs_ready;
          uart_dat_q <= hs_data;
          if (hs_sent) begin
            tx_en_q <= grant_oh;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          uart_rdy_q <= sel_ready;
          uart_dat_q <= sel_data;
          if (sel_complete) begin
            tx_en_q <= '0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          uart_rdy_q <= 1'b0;
          if (!sel_complete) begin
            if (|above_w) begin
              ch_q    <= lowest_set(above_w);
              state_q <= S_HDR;
            end else begin
`ifdef DAQ_SEQ_TRAILER_EN
              state_q <= S_TRAILER;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef DAQ_SEQ_TRAILER_EN
        S_TRAILER: begin
          uart_rdy_q <= hs_ready;
          uart_dat_q <= hs_data;
          if (hs_sent) state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          uart_rdy_q <= 1'b0;
          uart_dat_q <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign tx_en           = tx_en_q;
  assign uart_data_ready = uart_rdy_q;
  assign uart_data       = uart_dat_q;
  // Left unsynchronised on purpose: each channel synchronises it itself.
  assign ch_data_loaded  = tx_en_q & {N_CH{uart_loaded}};

endmodule
